// File: rtl/jpeg_block_sequencer_if.sv
// Handshake and status bundle between the JPEG block sequencer and its environment.
// The sequencer is the slave side; the controlling agent (or bench) is the master.
interface jpeg_block_sequencer_if;
    logic        start;
    logic        comp_is_luma;
    logic        huff_done;
    logic        abort;
    logic        start_ready;
    logic        input_enable;
    logic        dct_enable;
    logic        dct_end_enable;
    logic [7:0]  matrix_row;
    logic        zigzag_input_enable;
    logic        zigag_enable;
    logic        Huffman_start;
    logic        is_luminance;
    logic        block_done;
    logic        timeout_err;
    logic [15:0] block_count;

    modport master (
        output start, comp_is_luma, huff_done, abort,
        input  start_ready, input_enable, dct_enable, dct_end_enable, matrix_row,
               zigzag_input_enable, zigag_enable, Huffman_start, is_luminance,
               block_done, timeout_err, block_count
    );

    modport slave (
        input  start, comp_is_luma, huff_done, abort,
        output start_ready, input_enable, dct_enable, dct_end_enable, matrix_row,
               zigzag_input_enable, zigag_enable, Huffman_start, is_luminance,
               block_done, timeout_err, block_count
    );
endinterface

// File: rtl/jpeg_block_sequencer.sv
// Per-block control sequencer for a JPEG encoder pipeline: load, DCT, quantize rows,
// zigzag, then Huffman handoff with a bounded wait. All outputs are registered.
module jpeg_block_sequencer #(
    parameter int unsigned DCT_CYCLES   = 4,
    parameter int unsigned HUFF_TIMEOUT = 255
) (
    input logic                    clock,
    input logic                    reset_n,
    jpeg_block_sequencer_if.slave  bus
);

    typedef enum logic [3:0] {
        StIdle, StLoad, StDct, StDctEnd, StQuant, StZigzag, StHstart, StHwait, StDone
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        luma_q, luma_d;
    logic        timeout_d;
    logic [15:0] block_count_q, block_count_d;

    logic        start_ready_q, input_enable_q, dct_enable_q, dct_end_enable_q;
    logic [7:0]  matrix_row_q;
    logic        zigzag_input_enable_q, zigag_enable_q, huffman_start_q;
    logic        block_done_q, timeout_err_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        luma_d        = luma_q;
        timeout_d     = 1'b0;
        block_count_d = block_count_q;

        unique case (state_q)
            StIdle: begin
                // abort together with start keeps the block idle
                if (bus.start && !bus.abort) begin
                    state_d = StLoad;
                    luma_d  = bus.comp_is_luma;
                end
            end
            StLoad: begin
                state_d = StDct;
                cnt_d   = '0;
            end
            StDct: begin
                if (cnt_q == 16'(DCT_CYCLES - 1)) begin
                    state_d = StDctEnd;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StDctEnd: begin
                state_d = StQuant;
                cnt_d   = '0;
            end
            StQuant: begin
                // two cycles per row: cnt[3:1] is the row, cnt[0] marks the write cycle
                if (cnt_q == 16'd15) begin
                    state_d = StZigzag;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StZigzag: state_d = StHstart;
            StHstart: begin
                state_d = StHwait;
                cnt_d   = 16'd1;
            end
            StHwait: begin
                // completion wins over an expiring wait in the same cycle
                if (bus.huff_done) begin
                    state_d       = StDone;
                    cnt_d         = '0;
                    block_count_d = block_count_q + 16'd1;
                end else if (cnt_q == 16'(HUFF_TIMEOUT)) begin
                    state_d   = StIdle;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (state_q != StIdle && bus.abort) begin
            state_d       = StIdle;
            cnt_d         = '0;
            timeout_d     = 1'b0;
            block_count_d = block_count_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q               <= StIdle;
            cnt_q                 <= '0;
            luma_q                <= 1'b0;
            block_count_q         <= '0;
            start_ready_q         <= 1'b1;
            input_enable_q        <= 1'b0;
            dct_enable_q          <= 1'b0;
            dct_end_enable_q      <= 1'b0;
            matrix_row_q          <= '0;
            zigzag_input_enable_q <= 1'b0;
            zigag_enable_q        <= 1'b0;
            huffman_start_q       <= 1'b0;
            block_done_q          <= 1'b0;
            timeout_err_q         <= 1'b0;
        end else begin
            state_q               <= state_d;
            cnt_q                 <= cnt_d;
            luma_q                <= luma_d;
            block_count_q         <= block_count_d;
            start_ready_q         <= (state_d == StIdle);
            input_enable_q        <= (state_d == StLoad);
            dct_enable_q          <= (state_d == StDct);
            dct_end_enable_q      <= (state_d == StDctEnd);
            matrix_row_q          <= (state_d == StQuant) ? {5'd0, cnt_d[3:1]} : 8'd0;
            zigzag_input_enable_q <= (state_d == StQuant) && cnt_d[0];
            zigag_enable_q        <= (state_d == StZigzag);
            huffman_start_q       <= (state_d == StHstart);
            block_done_q          <= (state_d == StDone);
            timeout_err_q         <= timeout_d;
        end
    end

    assign bus.start_ready         = start_ready_q;
    assign bus.input_enable        = input_enable_q;
    assign bus.dct_enable          = dct_enable_q;
    assign bus.dct_end_enable      = dct_end_enable_q;
    assign bus.matrix_row          = matrix_row_q;
    assign bus.zigzag_input_enable = zigzag_input_enable_q;
    assign bus.zigag_enable        = zigag_enable_q;
    assign bus.Huffman_start       = huffman_start_q;
    assign bus.is_luminance        = luma_q;
    assign bus.block_done          = block_done_q;
    assign bus.timeout_err         = timeout_err_q;
    assign bus.block_count         = block_count_q;

endmodule

// File: tb/tb_jpeg_block_sequencer.sv
// Bench for jpeg_block_sequencer: a timeline model (cycle index since acceptance) is
// compared every cycle, with literal timing pins for directed blocks plus random traffic.
module tb_jpeg_block_sequencer;

    localparam int D  = 4;
    localparam int T  = 10;
    localparam int QS = D + 3;   // first QUANT cycle of a block
    localparam int ZZ = D + 19;
    localparam int HS = D + 20;
    localparam int HW = D + 21;  // first HWAIT cycle

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    jpeg_block_sequencer_if bus ();

    jpeg_block_sequencer #(
        .DCT_CYCLES   (D),
        .HUFF_TIMEOUT (T)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: a block is a timeline; m_t is the cycle index since acceptance (1 = load).
    bit          m_busy, m_done, m_tout, m_luma, preload, cmp_en;
    int          m_t;
    logic [15:0] m_count;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_tout  <= 1'b0;
            m_luma  <= 1'b0;
            m_t     <= 0;
            m_count <= '0;
        end else begin
            m_tout <= 1'b0;
            if (preload) m_count <= 16'hFFFF;
            if (m_done) begin
                m_done <= 1'b0;
            end else if (!m_busy) begin
                if (bus.start && !bus.abort) begin
                    m_busy <= 1'b1;
                    m_t    <= 1;
                    m_luma <= bus.comp_is_luma;
                end
            end else if (bus.abort) begin
                m_busy <= 1'b0;
            end else if (m_t >= HW) begin
                if (bus.huff_done) begin
                    m_busy  <= 1'b0;
                    m_done  <= 1'b1;
                    m_count <= m_count + 16'd1;
                end else if (m_t - HS == T) begin
                    m_busy <= 1'b0;
                    m_tout <= 1'b1;
                end else begin
                    m_t <= m_t + 1;
                end
            end else begin
                m_t <= m_t + 1;
            end
        end
    end

    always @(negedge clock) begin : cmp
        int q;
        bit quant;
        int strobes;
        if (cmp_en) begin
            q     = m_t - QS;
            quant = m_busy && m_t >= QS && m_t < QS + 16;
            check("start_ready", bus.start_ready, !m_busy && !m_done);
            check("input_enable", bus.input_enable, m_busy && m_t == 1);
            check("dct_enable", bus.dct_enable, m_busy && m_t >= 2 && m_t <= D + 1);
            check("dct_end_enable", bus.dct_end_enable, m_busy && m_t == D + 2);
            check("matrix_row", bus.matrix_row, quant ? q / 2 : 0);
            check("zigzag_input_enable", bus.zigzag_input_enable, quant && (q % 2 == 1));
            check("zigag_enable", bus.zigag_enable, m_busy && m_t == ZZ);
            check("Huffman_start", bus.Huffman_start, m_busy && m_t == HS);
            check("block_done", bus.block_done, m_done);
            check("timeout_err", bus.timeout_err, m_tout);
            check("is_luminance", bus.is_luminance, m_luma);
            check("block_count", bus.block_count, m_count);
            strobes = int'(bus.input_enable) + int'(bus.dct_end_enable) +
                      int'(bus.zigag_enable) + int'(bus.Huffman_start);
            check("strobe_onehot", strobes <= 1, 1);
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    // Start a block (sampled at edge 0) and observe cycles 1..len.
    task automatic run_block(input bit luma, input int hd_at, input int ab_at, input int rst_at,
                             input bit pulse_start, input int len,
                             output int bd_at, output int to_at, output int idle_at);
        bd_at   = -1;
        to_at   = -1;
        idle_at = -1;
        tick();
        bus.start        = 1'b1;
        bus.comp_is_luma = luma;
        for (int c = 1; c <= len; c++) begin
            @(negedge clock);
            if (bus.block_done && bd_at < 0) bd_at = c;
            if (bus.timeout_err && to_at < 0) to_at = c;
            if (bus.start_ready && idle_at < 0) idle_at = c;
            #1;
            bus.start     = pulse_start && c >= 2 && c <= 11 && (c % 2 == 1);
            bus.huff_done = (c == hd_at);
            bus.abort     = (c == ab_at);
            reset_n       = !(c == rst_at);
        end
        bus.start     = 1'b0;
        bus.huff_done = 1'b0;
        bus.abort     = 1'b0;
        reset_n       = 1'b1;
    endtask

    initial begin
        int first_ie, first_dct, n_dct, first_de, first_zz, first_hs, first_bd, n_zin, cnt26;
        bit row_ok, luma_ok;
        int bd, to, idle;

        bus.start        = 1'b0;
        bus.comp_is_luma = 1'b0;
        bus.huff_done    = 1'b0;
        bus.abort        = 1'b0;
        preload          = 1'b0;
        cmp_en           = 1'b0;

        repeat (2) @(posedge clock);
        cmp_en = 1'b1;
        @(negedge clock);
        check("reset start_ready", bus.start_ready, 1);
        check("reset block_count", bus.block_count, 0);
        check("reset is_luminance", bus.is_luminance, 0);

        // Release reset with start already high: accepted at the first edge.
        #1;
        reset_n          = 1'b1;
        bus.start        = 1'b1;
        bus.comp_is_luma = 1'b1;
        first_ie = -1; first_dct = -1; n_dct = 0; first_de = -1;
        first_zz = -1; first_hs = -1; first_bd = -1; n_zin = 0; cnt26 = -1;
        row_ok = 1'b1; luma_ok = 1'b1;
        for (int c = 1; c <= 27; c++) begin
            @(negedge clock);
            if (bus.input_enable && first_ie < 0) first_ie = c;
            if (bus.dct_enable && first_dct < 0) first_dct = c;
            if (bus.dct_enable) n_dct++;
            if (bus.dct_end_enable && first_de < 0) first_de = c;
            if (bus.zigag_enable && first_zz < 0) first_zz = c;
            if (bus.Huffman_start && first_hs < 0) first_hs = c;
            if (bus.block_done && first_bd < 0) first_bd = c;
            if (bus.zigzag_input_enable) n_zin++;
            if (c >= 7 && c <= 22) begin
                if (bus.matrix_row != 8'((c - 7) / 2)) row_ok = 1'b0;
                if (bus.zigzag_input_enable != ((c - 7) % 2 == 1)) row_ok = 1'b0;
            end
            if (c <= 26 && !bus.is_luminance) luma_ok = 1'b0;
            if (c == 26) cnt26 = int'(bus.block_count);
            #1;
            bus.start     = 1'b0;
            bus.huff_done = (c == 25);
        end
        check("pin input_enable cycle", first_ie, 1);
        check("pin dct_enable first", first_dct, 2);
        check("pin dct_enable length", n_dct, 4);
        check("pin dct_end cycle", first_de, 6);
        check("pin zigag cycle", first_zz, 23);
        check("pin Huffman_start cycle", first_hs, 24);
        check("pin block_done cycle", first_bd, 26);
        check("pin block_count after first", cnt26, 1);
        check("pin quant row sequence", row_ok, 1);
        check("pin zigzag_input pulses", n_zin, 8);
        check("pin is_luminance held", luma_ok, 1);

        // Timeout: 10 HWAIT cycles (25..34) elapse; pulse registered in cycle 35.
        run_block(1'b0, -1, -1, -1, 1'b0, 40, bd, to, idle);
        check("timeout pulse cycle", to, 35);
        check("timeout no done", bd, -1);
        check("timeout idle cycle", idle, 35);
        check("timeout count kept", bus.block_count, 1);

        // huff_done on the expiring cycle counts as success.
        run_block(1'b1, 34, -1, -1, 1'b0, 40, bd, to, idle);
        check("expiry+done success", bd, 35);
        check("expiry+done no timeout", to, -1);

        run_block(1'b1, -1, 3, -1, 1'b0, 30, bd, to, idle);
        check("abort dct idle", idle, 4);
        check("abort dct no done", bd, -1);
        run_block(1'b0, -1, 13, -1, 1'b0, 30, bd, to, idle);
        check("abort quant row3 idle", idle, 14);
        check("abort quant no done", bd, -1);
        run_block(1'b1, -1, 27, -1, 1'b0, 30, bd, to, idle);
        check("abort hwait idle", idle, 28);
        check("abort hwait no done", bd, -1);
        check("abort count kept", bus.block_count, 2);

        run_block(1'b0, 25, -1, -1, 1'b1, 30, bd, to, idle);
        check("busy start ignored done", bd, 26);
        check("busy start idle", idle, 27);
        check("busy start count", bus.block_count, 3);

        run_block(1'b1, -1, -1, 12, 1'b1, 20, bd, to, idle);
        check("reset mid quant idle", idle, 13);
        check("reset mid quant no done", bd, -1);
        check("reset count cleared", bus.block_count, 0);
        check("reset luma cleared", bus.is_luminance, 0);

        // Wrap: preset the counter to 0xFFFF, then one completion.
        tick();
        force dut.block_count_q = 16'hFFFF;
        preload = 1'b1;
        tick();
        release dut.block_count_q;
        preload = 1'b0;
        run_block(1'b0, 25, -1, -1, 1'b0, 30, bd, to, idle);
        check("wrap done", bd, 26);
        check("wrap count", bus.block_count, 0);

        for (int i = 0; i < 2500; i++) begin
            tick();
            bus.start        = ($urandom_range(0, 3) == 0);
            bus.comp_is_luma = 1'($urandom_range(0, 1));
            bus.abort        = ($urandom_range(0, 63) == 0);
            bus.huff_done    = ($urandom_range(0, 5) == 0);
            reset_n          = ($urandom_range(0, 599) != 0);
        end
        tick();
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.huff_done = 1'b0;
        reset_n       = 1'b1;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
